// File: rtl/pb_seg7_scan_pkg.sv
// Shared constants for the PicoBlaze-style 4-digit seven-segment scanner:
// register offsets, CTRL bit positions, scan state type and segment patterns.
package pb_seg7_scan_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] OFF_DIGIT0 = 8'd0;
  localparam logic [7:0] OFF_DIGIT1 = 8'd1;
  localparam logic [7:0] OFF_DIGIT2 = 8'd2;
  localparam logic [7:0] OFF_DIGIT3 = 8'd3;
  localparam logic [7:0] OFF_CTRL   = 8'd4;
  localparam logic [7:0] OFF_STATUS = 8'd5;
  localparam logic [7:0] OFF_BRIGHT = 8'd6;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_RAW_BIT    = 1;
  localparam int CTRL_BLANK_LSB  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Active-low {g,f,e,d,c,b,a}; the decimal point is added by the caller.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [3:0] anode_onehot_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/pb_seg7_scan_if.sv
// CPU port bus seen by the scanner: port_id/data_in/strobes in, data_out back.
interface pb_seg7_scan_if;

  // Strobes are single-cycle qualifiers with no backpressure: a write lands on
  // the edge where write_strobe=1; read data is valid the cycle after
  // read_strobe=1 and is 8'h00 otherwise so it can be ORed onto a shared bus.
  logic [7:0] port_id;
  logic [7:0] data_in;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] data_out;

  modport master (
    output port_id, data_in, write_strobe, read_strobe,
    input  data_out
  );

  modport slave (
    input  port_id, data_in, write_strobe, read_strobe,
    output data_out
  );

endinterface

// File: rtl/pb_seg7_scan_seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern {g..a}.
module seg7_hex_decoder
  import pb_seg7_scan_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG7_LUT[i_hex];

endmodule

// File: rtl/pb_seg7_scan.sv
// Four-digit multiplexed seven-segment driver behind a CPU port window.
// Optional PWM brightness register enabled with `define PB_SEG7_BRIGHTNESS_EN.
module pb_seg7_scan
  import pb_seg7_scan_pkg::*;
#(
    parameter logic [7:0] BASE_ADDRESS = 8'h10,
    parameter int         SCAN_DIV     = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    pb_seg7_scan_if.slave        bus,
    output logic [3:0]           anode,
    output logic [7:0]           cathode,
    output scan_state_t          o_dbg_state
);

    localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [7:0]    r_digit [NUM_DIGITS];
    logic [7:0]    r_ctrl;
    logic [7:0]    r_dout;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    r_anode;
    logic [7:0]    r_cathode;
    scan_state_t   r_state;
    scan_state_t   w_next_state;

    logic [7:0]    w_off;
    logic          w_wr_ctrl;
    logic [7:0]    w_sel;
    logic [6:0]    w_seg;
    logic [3:0]    w_blank_mask;
    logic          w_blank;
    logic          w_lit;
    logic [3:0]    w_anode;
    logic [7:0]    w_cathode;
    logic [7:0]    w_rd_data;

    assign w_off     = bus.port_id - BASE_ADDRESS;
    assign w_wr_ctrl = bus.write_strobe && (w_off == OFF_CTRL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 8'h00;
            r_ctrl <= 8'h00;
        end else if (bus.write_strobe) begin
            case (w_off)
                OFF_DIGIT0: r_digit[0] <= bus.data_in;
                OFF_DIGIT1: r_digit[1] <= bus.data_in;
                OFF_DIGIT2: r_digit[2] <= bus.data_in;
                OFF_DIGIT3: r_digit[3] <= bus.data_in;
                OFF_CTRL:   r_ctrl     <= bus.data_in;
                default:    ;
            endcase
        end
    end

`ifdef PB_SEG7_BRIGHTNESS_EN
    logic [3:0]  r_bright;
    logic [31:0] w_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bright <= 4'hF;
        end else if (bus.write_strobe && (w_off == OFF_BRIGHT)) begin
            r_bright <= bus.data_in[3:0];
        end
    end

    // Lit for the leading portion of each slot, in 1/16ths of the slot.
    assign w_level = (32'(r_presc) << 4) / 32'(SCAN_DIV);
    assign w_lit   = (w_level <= {28'd0, r_bright});
`else
    assign w_lit = 1'b1;
`endif

    // The state tracks ENABLE in the same cycle the CTRL write lands.
    always_comb begin
        w_next_state = r_state;
        if (w_wr_ctrl) begin
            w_next_state = bus.data_in[CTRL_ENABLE_BIT] ? ST_SCAN : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Counting only while staying in SCAN keeps a fresh enable at index 0, prescaler 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if ((r_state == ST_IDLE) || (w_next_state == ST_IDLE)) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_sel        = r_digit[r_idx];
    assign w_blank_mask = r_ctrl[CTRL_BLANK_LSB +: 4];
    assign w_blank      = w_blank_mask[r_idx];

    seg7_hex_decoder u_hex_dec (
        .i_hex (w_sel[3:0]),
        .o_seg (w_seg)
    );

    always_comb begin
        w_anode   = 4'hF;
        w_cathode = 8'hFF;
        if (r_state == ST_SCAN) begin
            if (!w_blank && w_lit) begin
                w_anode = anode_onehot_n(r_idx);
            end
            w_cathode = r_ctrl[CTRL_RAW_BIT] ? ~w_sel : {~w_sel[7], w_seg};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_anode   <= 4'hF;
            r_cathode <= 8'hFF;
        end else begin
            r_anode   <= w_anode;
            r_cathode <= w_cathode;
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (w_off)
            OFF_DIGIT0: w_rd_data = r_digit[0];
            OFF_DIGIT1: w_rd_data = r_digit[1];
            OFF_DIGIT2: w_rd_data = r_digit[2];
            OFF_DIGIT3: w_rd_data = r_digit[3];
            OFF_CTRL:   w_rd_data = r_ctrl;
            OFF_STATUS: w_rd_data = {5'd0, (r_state == ST_SCAN), r_idx};
`ifdef PB_SEG7_BRIGHTNESS_EN
            OFF_BRIGHT: w_rd_data = {4'd0, r_bright};
`endif
            default:    w_rd_data = 8'h00;
        endcase
    end

    // Read data is sampled before any same-cycle write takes effect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout <= 8'h00;
        end else begin
            r_dout <= bus.read_strobe ? w_rd_data : 8'h00;
        end
    end

    assign bus.data_out = r_dout;
    assign anode        = r_anode;
    assign cathode      = r_cathode;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pb_seg7_scan.sv
// Self-checking bench for pb_seg7_scan: behavioural model checked every cycle
// plus directed literal checks of scan order, blanking, raw mode and reset.
module tb_pb_seg7_scan;

  localparam logic [7:0] BASE = 8'h10;
  localparam int         D    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] anode;
  logic [7:0] cathode;
  logic       dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  pb_seg7_scan_if bus_if ();

  pb_seg7_scan #(.BASE_ADDRESS(BASE), .SCAN_DIV(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .anode       (anode),
    .cathode     (cathode),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
    $fatal(1);
  end

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Active-low {dp,g,f,e,d,c,b,a} with dp off.
  logic [7:0] hex_pat [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic [7:0] m_digit [4];
  logic [7:0] m_ctrl;
  bit         m_en;
  int         m_en_edge;
  int         edge_n = 0;
  int         m_t;
  int         m_idx;
  logic [7:0] m_off;
  logic [3:0] e_anode;
  logic [7:0] e_cath;
  logic [7:0] e_dout;
  logic       e_state;
  bit         e_valid = 0;

  // The scan position follows from how many edges have passed since ENABLE rose.
  always @(posedge clk) begin
    edge_n++;
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_digit[i] = 8'h00;
      m_ctrl  = 8'h00;
      m_en    = 0;
      e_anode = 4'hF;
      e_cath  = 8'hFF;
      e_dout  = 8'h00;
      e_state = 1'b0;
    end else begin
      if (m_en) begin
        m_t   = edge_n - 1 - m_en_edge;
        m_idx = (m_t / D) % 4;
      end else begin
        m_idx = 0;
      end
      if (!m_en) begin
        e_anode = 4'hF;
        e_cath  = 8'hFF;
      end else begin
        e_anode = m_ctrl[4 + m_idx] ? 4'hF : ~(4'b0001 << m_idx);
        if (m_ctrl[1]) e_cath = ~m_digit[m_idx];
        else           e_cath = {~m_digit[m_idx][7], hex_pat[m_digit[m_idx][3:0]][6:0]};
      end
      m_off  = bus_if.port_id - BASE;
      e_dout = 8'h00;
      if (bus_if.read_strobe) begin
        if (m_off < 8'd4)       e_dout = m_digit[m_off[1:0]];
        else if (m_off == 8'd4) e_dout = m_ctrl;
        else if (m_off == 8'd5) e_dout = {5'd0, m_en, 2'(m_idx)};
      end
      if (bus_if.write_strobe) begin
        if (m_off < 8'd4) m_digit[m_off[1:0]] = bus_if.data_in;
        else if (m_off == 8'd4) begin
          m_ctrl = bus_if.data_in;
          if (bus_if.data_in[0] && !m_en) begin
            m_en      = 1;
            m_en_edge = edge_n;
          end else if (!bus_if.data_in[0]) begin
            m_en = 0;
          end
        end
      end
      e_state = m_en;
    end
    e_valid = 1;
  end

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    #1;
    if (e_valid) begin
      chk("model_anode",   32'(anode),     32'(e_anode));
      chk("model_cathode", 32'(cathode),   32'(e_cath));
      chk("model_dout",    32'(bus_if.data_out), 32'(e_dout));
      chk("model_state",   32'(dbg_state), 32'(e_state));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_cycle(input logic [7:0] pid, input logic [7:0] din, input bit we, input bit re);
    @(negedge clk);
    bus_if.port_id      = pid;
    bus_if.data_in      = din;
    bus_if.write_strobe = we;
    bus_if.read_strobe  = re;
    @(negedge clk);
    bus_if.write_strobe = 1'b0;
    bus_if.read_strobe  = 1'b0;
  endtask

  task automatic wait_anode(input logic [3:0] a, input string nm);
    bit found;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if (anode == a) found = 1;
    end
    chk({nm, "_seen"}, 32'(found), 32'd1);
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [3:0] slot_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] slot_ca [4] = '{8'hF9, 8'hA4, 8'h30, 8'h8E};

  initial begin
    int cnt;
    int cnt_d;
    int cnt_f;
    bus_if.port_id      = 8'h00;
    bus_if.data_in      = 8'h00;
    bus_if.write_strobe = 1'b0;
    bus_if.read_strobe  = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // reset state
    bus_cycle(BASE + 8'd4, 8'h00, 0, 1);
    chk("rd_ctrl_reset", 32'(bus_if.data_out), 32'h00);
    bus_cycle(BASE + 8'd5, 8'h00, 0, 1);
    chk("rd_status_reset", 32'(bus_if.data_out), 32'h00);
    chk("anode_reset", 32'(anode), 32'hF);
    chk("cathode_reset", 32'(cathode), 32'hFF);

    // digits, read-back latency, foreign port
    bus_cycle(BASE + 8'd0, 8'h01, 1, 0);
    bus_cycle(BASE + 8'd1, 8'h02, 1, 0);
    bus_cycle(BASE + 8'd2, 8'h83, 1, 0);
    bus_cycle(BASE + 8'd3, 8'h0F, 1, 0);
    bus_cycle(8'h20, 8'h00, 0, 1);
    chk("rd_foreign", 32'(bus_if.data_out), 32'h00);
    bus_cycle(BASE, 8'h00, 0, 1);
    chk("rd_digit0", 32'(bus_if.data_out), 32'h01);
    @(posedge clk); #1;
    chk("rd_digit0_after", 32'(bus_if.data_out), 32'h00);

    // read and write of the same register in one cycle returns the old value
    bus_cycle(BASE + 8'd1, 8'hA5, 1, 1);
    chk("rd_same_cycle_old", 32'(bus_if.data_out), 32'h02);
    bus_cycle(BASE + 8'd1, 8'h00, 0, 1);
    chk("rd_same_cycle_new", 32'(bus_if.data_out), 32'hA5);
    bus_cycle(BASE + 8'd1, 8'h02, 1, 0);

    // decode scan order and slot length
    bus_cycle(BASE + 8'd4, 8'h01, 1, 0);
    wait_anode(4'hE, "first_slot");
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("slot%0d_anode", s), 32'(anode), 32'(slot_an[s]));
      chk($sformatf("slot%0d_cathode", s), 32'(cathode), 32'(slot_ca[s]));
      cnt = 0;
      while (anode == slot_an[s] && cnt < 10) begin
        cnt++;
        @(posedge clk); #1;
      end
      chk($sformatf("slot%0d_len", s), 32'(cnt), 32'(D));
    end

    // blank digit1
    bus_cycle(BASE + 8'd4, 8'h21, 1, 0);
    repeat (2) @(posedge clk);
    cnt_d = 0;
    cnt_f = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (anode == 4'hD) cnt_d++;
      if (anode == 4'hF) cnt_f++;
    end
    chk("blank_d_count", 32'(cnt_d), 32'd0);
    chk("blank_f_count", 32'(cnt_f), 32'd4);

    // raw mode
    bus_cycle(BASE + 8'd4, 8'h03, 1, 0);
    bus_cycle(BASE + 8'd2, 8'h55, 1, 0);
    wait_anode(4'hB, "raw_slot2");
    chk("raw_cathode", 32'(cathode), 32'hAA);

    // disable mid-slot 2, then re-enable
    bus_cycle(BASE + 8'd4, 8'h01, 1, 0);
    bus_cycle(BASE + 8'd2, 8'h83, 1, 0);
    wait_anode(4'hB, "pre_disable");
    @(posedge clk); #1;
    bus_cycle(BASE + 8'd4, 8'h00, 1, 0);
    @(posedge clk); #1;
    chk("disable_anode", 32'(anode), 32'hF);
    chk("disable_cathode", 32'(cathode), 32'hFF);
    repeat (3) @(posedge clk);
    bus_cycle(BASE + 8'd4, 8'h01, 1, 0);
    @(posedge clk); #1;
    chk("resume_anode", 32'(anode), 32'hE);
    chk("resume_cathode", 32'(cathode), 32'hF9);

    // asynchronous reset mid-scan
    repeat (6) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_anode", 32'(anode), 32'hF);
    chk("async_rst_cathode", 32'(cathode), 32'hFF);
    @(negedge clk);
    reset = 1'b1;
    bus_cycle(BASE, 8'h00, 0, 1);
    chk("rst_digit0_cleared", 32'(bus_if.data_out), 32'h00);
    chk("rst_idle_anode", 32'(anode), 32'hF);

    // randomized traffic checked by the model
    for (int it = 0; it < 400; it++) begin
      logic [7:0] pid;
      logic [7:0] din;
      int op;
      op  = $urandom_range(0, 5);
      din = 8'($urandom);
      case (op)
        0: bus_cycle(8'(BASE + 8'($urandom_range(0, 3))), din, 1, 0);
        1: begin
          din[0] = ($urandom_range(0, 4) != 0);
          bus_cycle(BASE + 8'd4, din, 1, 0);
        end
        2: bus_cycle(8'(BASE - 8'd2 + 8'($urandom_range(0, 10))), 8'h00, 0, 1);
        3: begin
          pid = 8'($urandom);
          bus_cycle(pid, din, $urandom_range(0, 1) == 1, 1);
        end
        4: bus_cycle(8'(BASE + 8'($urandom_range(0, 7))), din, 1, 1);
        default: repeat ($urandom_range(1, 6)) @(negedge clk);
      endcase
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
